// File: rtl/pipe_reg_chain_pkg.sv
// Shared constants and helpers for the pipe_reg_chain register pipeline.
// Holds the default geometry and the width rule for the occupancy counter.
package pipe_reg_chain_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 2;

  // Wide enough for DEPTH stages plus the optional skid entry.
  function automatic int count_width(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// pipe_stage: one valid+data register of the chain with load enable,
// asynchronous reset and a synchronous clear that only drops the valid bit.
module pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Clear wins over load; payload is left untouched when cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH-stage valid/ready register pipeline with bubble collapse.
// Define PIPE_REG_CHAIN_SKID_EN to add a one-entry input skid buffer that cuts out_ready -> in_ready.
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int CW    = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] stageValid;
  logic [WIDTH-1:0] stageData [DEPTH];
  logic [DEPTH-1:0] stageLoad;
  logic             srcValid;
  logic [WIDTH-1:0] srcData;
  logic             accept;
  logic [CW-1:0]    countSum;

  // A stage may load when it, or any stage downstream of it, has a hole,
  // or when the output is being consumed so the whole chain shifts.
  always_comb begin
    stageLoad = '0;
    for (int i = 0; i < DEPTH; i++) begin
      stageLoad[i] = out_ready;
      for (int j = i; j < DEPTH; j++) begin
        if (!stageValid[j]) stageLoad[i] = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : gStage
    logic             upValid;
    logic [WIDTH-1:0] upData;
    if (i == 0) begin : gHead
      assign upValid = srcValid;
      assign upData  = srcData;
    end else begin : gBody
      assign upValid = stageValid[i-1];
      assign upData  = stageData[i-1];
    end
    pipe_stage #(.WIDTH(WIDTH)) uStage (
      .clk     (clk),
      .reset   (reset),
      .load_i  (stageLoad[i]),
      .clear_i (flush),
      .valid_i (upValid),
      .data_i  (upData),
      .valid_o (stageValid[i]),
      .data_o  (stageData[i])
    );
  end

  assign out_valid = stageValid[DEPTH-1];
  assign out_data  = stageData[DEPTH-1];

`ifdef PIPE_REG_CHAIN_SKID_EN
  logic             skidValid_q, skidValid_d;
  logic [WIDTH-1:0] skidData_q, skidData_d;

  assign in_ready = !reset && !flush && !skidValid_q;
  assign accept   = in_valid && in_ready;

  // A parked beat always feeds stage 0 first, so order is kept; a new beat
  // only parks when stage 0 cannot take it this cycle.
  always_comb begin
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    srcValid    = skidValid_q || accept;
    srcData     = skidValid_q ? skidData_q : in_data;
    if (flush) begin
      skidValid_d = 1'b0;
    end else if (skidValid_q) begin
      if (stageLoad[0]) skidValid_d = 1'b0;
    end else if (accept && !stageLoad[0]) begin
      skidValid_d = 1'b1;
      skidData_d  = in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
    end else begin
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
    end
  end

  always_comb begin
    countSum = CW'(skidValid_q);
    for (int i = 0; i < DEPTH; i++) countSum = countSum + CW'(stageValid[i]);
  end
`else
  assign in_ready = !reset && !flush && stageLoad[0];
  assign accept   = in_valid && in_ready;

  always_comb begin
    srcValid = accept;
    srcData  = in_data;
  end

  always_comb begin
    countSum = '0;
    for (int i = 0; i < DEPTH; i++) countSum = countSum + CW'(stageValid[i]);
  end
`endif

  assign count = countSum;

endmodule
